// File: rtl/uart_char_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_char_rx
// Purpose  : Oversampling UART byte receiver, 8 data bits LSB first, 1 stop
//            bit. i_rx is sampled on i_baud ticks (OSR ticks per bit). Each
//            bit is decided by a 3-sample majority vote around mid-bit. A good
//            byte appears on o_char together with a 1-cycle o_finished strobe.
// Optional : UART_CHAR_RX_PARITY_EN adds a parity bit between data and stop
//            (PARITY_ODD selects odd parity) plus the o_parity_err strobe.
// Ports    : i_clk        system clock
//            i_rst        asynchronous active-low reset
//            i_baud       oversample tick, one i_clk wide, OSR x bit rate
//            i_rx         asynchronous serial line, idle high
//            o_char       last good byte, held until the next good frame
//            o_finished   1-cycle strobe, o_char updated this cycle
//            o_frame_err  1-cycle strobe, stop bit sampled low
//            o_busy       high whenever the receiver is not idle
//            o_parity_err 1-cycle strobe with o_finished (parity build only)
// Revision : 1.0  initial release
// ============================================================================
module uart_char_rx #(
    parameter int OSR        = 16
`ifdef UART_CHAR_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    input  wire logic       i_baud,
    input  wire logic       i_rx,
    output logic [7:0]      o_char,
    output logic            o_finished,
    output logic            o_frame_err,
`ifdef UART_CHAR_RX_PARITY_EN
    output logic            o_parity_err,
`endif
    output logic            o_busy
);

    localparam int PW = $clog2(OSR);

    // Sample points: the two early votes are stored, the third is taken live
    // on the decision tick.
    localparam logic [PW-1:0] c_PH_A    = PW'(OSR / 2 - 1);
    localparam logic [PW-1:0] c_PH_B    = PW'(OSR / 2);
    localparam logic [PW-1:0] c_PH_DEC  = PW'(OSR / 2 + 1);
    localparam logic [PW-1:0] c_PH_LAST = PW'(OSR - 1);

    generate
        if ((OSR < 8) || ((OSR % 2) != 0)) begin : g_osr_check
            $error("uart_char_rx: OSR must be even and at least 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
`ifdef UART_CHAR_RX_PARITY_EN
        ,
        S_PARITY    = 3'd5
`endif
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [PW-1:0]   phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            samp_a_q, samp_a_d;
    logic            samp_b_q, samp_b_d;
    logic [7:0]      char_q, char_d;
    logic            fin_q, fin_d;
    logic            ferr_q, ferr_d;
`ifdef UART_CHAR_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    logic            w_maj;
    logic            w_dec;
    logic            w_wrap;

    assign w_maj  = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);
    assign w_dec  = (phase_q == c_PH_DEC);
    assign w_wrap = (phase_q == c_PH_LAST);

    // phase_q holds the phase number of the tick currently being processed.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        samp_a_d = samp_a_q;
        samp_b_d = samp_b_q;
        char_d   = char_q;
        fin_d    = 1'b0;
        ferr_d   = 1'b0;
`ifdef UART_CHAR_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = 1'b0;
`endif
        if (i_baud) begin
            if ((state_q != S_IDLE) && (state_q != S_WAIT_HIGH)) begin
                phase_d = w_wrap ? '0 : phase_q + PW'(1);
                if (phase_q == c_PH_A) begin
                    samp_a_d = rx_s_q;
                end
                if (phase_q == c_PH_B) begin
                    samp_b_d = rx_s_q;
                end
            end
            case (state_q)
                S_IDLE: begin
                    // The detecting tick is phase 0, so the next one is 1.
                    if (!rx_s_q) begin
                        state_d = S_START;
                        phase_d = PW'(1);
                        bit_d   = 3'd0;
                    end
                end
                S_START: begin
                    if (w_dec && w_maj) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                    end else if (w_wrap) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                end
                S_DATA: begin
                    if (w_dec) begin
                        shift_d = {w_maj, shift_q[7:1]};
                    end
                    if (w_wrap) begin
                        if (bit_q == 3'd7) begin
`ifdef UART_CHAR_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                            bit_d   = 3'd0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
`ifdef UART_CHAR_RX_PARITY_EN
                S_PARITY: begin
                    if (w_dec) begin
                        par_d = w_maj;
                    end
                    if (w_wrap) begin
                        state_d = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Return to IDLE at the decision tick so the remainder of
                    // the stop bit is absorbed there and a back-to-back start
                    // edge is caught on time.
                    if (w_dec) begin
                        phase_d = '0;
                        if (w_maj) begin
                            char_d  = shift_q;
                            fin_d   = 1'b1;
`ifdef UART_CHAR_RX_PARITY_EN
                            perr_d  = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // A stuck-low line must not look like a new start bit.
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            phase_q   <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            samp_a_q  <= 1'b0;
            samp_b_q  <= 1'b0;
            char_q    <= 8'd0;
            fin_q     <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_CHAR_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            samp_a_q  <= samp_a_d;
            samp_b_q  <= samp_b_d;
            char_q    <= char_d;
            fin_q     <= fin_d;
            ferr_q    <= ferr_d;
`ifdef UART_CHAR_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign o_char       = char_q;
    assign o_finished   = fin_q;
    assign o_frame_err  = ferr_q;
    assign o_busy       = (state_q != S_IDLE);
`ifdef UART_CHAR_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif

endmodule
`default_nettype wire
